// File: rtl/ps2_host_tx.sv
// ps2_host_tx
// Host-to-device PS/2 transmitter. It sends one command byte to the device
// over the open-drain clock/data pair: it inhibits the bus, issues a
// request-to-send, shifts out the 11-bit host frame on device-generated
// clock falling edges, and samples the device acknowledge bit.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   start        single-cycle request, honoured only while idle
//   tx_data      byte to send, captured when start is accepted
//   ps2_clk_in   raw PS/2 clock line level (asynchronous to clk)
//   ps2_data_in  raw PS/2 data line level (asynchronous to clk)
//   ps2_clk_oe   1 = pull PS/2 clock low, 0 = release
//   ps2_data_oe  1 = pull PS/2 data low, 0 = release
//   busy         high from the cycle after an accepted start until back in idle
//   done         one-cycle pulse at the end of every transfer
//   ack_ok       device acknowledged; valid with done, held until next start
//   err_timeout  device stopped clocking; valid with done, held until next start
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES  = 5000,
    parameter int REQ_HOLD_CYCLES = 50,
    parameter int TIMEOUT_CYCLES  = 750000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] tx_data,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    output logic       busy,
    output logic       done,
    output logic       ack_ok,
    output logic       err_timeout
);

    localparam int MAX_AB     = (INHIBIT_CYCLES > REQ_HOLD_CYCLES) ? INHIBIT_CYCLES : REQ_HOLD_CYCLES;
    localparam int MAX_CYCLES = (MAX_AB > TIMEOUT_CYCLES) ? MAX_AB : TIMEOUT_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_ACK,
        S_WAIT_IDLE,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [9:0]         shift_q, shift_d;
    logic [3:0]         edge_cnt_q, edge_cnt_d;
    logic               data_oe_q, data_oe_d;
    logic               ack_ok_q, ack_ok_d;
    logic               err_q, err_d;

    logic clk_meta_q, clk_sync_q, clk_prev_q;
    logic data_meta_q, data_sync_q;

    logic clk_fall;
    logic timed_out;
    logic [3:0] edge_cnt_inc;

    // Two-flop synchronisers for both lines plus one extra clock stage for
    // falling-edge detection. Reset to the idle (pulled-up) line level so no
    // spurious edge is seen right after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta_q  <= 1'b1;
            clk_sync_q  <= 1'b1;
            clk_prev_q  <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
        end else begin
            clk_meta_q  <= ps2_clk_in;
            clk_sync_q  <= clk_meta_q;
            clk_prev_q  <= clk_sync_q;
            data_meta_q <= ps2_data_in;
            data_sync_q <= data_meta_q;
        end
    end

    assign clk_fall     = clk_prev_q & ~clk_sync_q;
    // The counter stops at the limit rather than wrapping.
    assign timed_out    = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));
    assign edge_cnt_inc = (edge_cnt_q == 4'd11) ? 4'd11 : edge_cnt_q + 4'd1;

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            edge_cnt_q <= '0;
            data_oe_q  <= 1'b0;
            ack_ok_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shift_q    <= shift_d;
            edge_cnt_q <= edge_cnt_d;
            data_oe_q  <= data_oe_d;
            ack_ok_q   <= ack_ok_d;
            err_q      <= err_d;
        end
    end

    // Next-state logic. cnt is shared: it times the inhibit and request
    // phases, then becomes the clock-edge watchdog once the clock is released.
    // A falling edge is always checked before the watchdog so an edge arriving
    // in the expiry cycle still counts.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shift_d    = shift_q;
        edge_cnt_d = edge_cnt_q;
        data_oe_d  = data_oe_q;
        ack_ok_d   = ack_ok_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: begin
                data_oe_d = 1'b0;
                if (start) begin
                    state_d    = S_INHIBIT;
                    cnt_d      = '0;
                    shift_d    = {1'b1, ~^tx_data, tx_data};
                    edge_cnt_d = '0;
                    ack_ok_d   = 1'b0;
                    err_d      = 1'b0;
                end
            end
            S_INHIBIT: begin
                if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
                    state_d   = S_REQ;
                    cnt_d     = '0;
                    data_oe_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_REQ: begin
                if (cnt_q == CNT_W'(REQ_HOLD_CYCLES - 1)) begin
                    state_d = S_SEND;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_SEND: begin
                // The start bit is already on the line; each falling edge
                // presents the next frame bit, LSB first.
                if (clk_fall) begin
                    data_oe_d  = ~shift_q[0];
                    shift_d    = {1'b0, shift_q[9:1]};
                    edge_cnt_d = edge_cnt_inc;
                    cnt_d      = '0;
                    if (edge_cnt_q == 4'd9) begin
                        state_d = S_ACK;
                    end
                end else if (timed_out) begin
                    state_d   = S_DONE;
                    data_oe_d = 1'b0;
                    err_d     = 1'b1;
                    ack_ok_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_ACK: begin
                data_oe_d = 1'b0;
                if (clk_fall) begin
                    ack_ok_d   = ~data_sync_q;
                    edge_cnt_d = edge_cnt_inc;
                    cnt_d      = '0;
                    state_d    = S_WAIT_IDLE;
                end else if (timed_out) begin
                    state_d  = S_DONE;
                    err_d    = 1'b1;
                    ack_ok_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_WAIT_IDLE: begin
                data_oe_d = 1'b0;
                if (clk_sync_q && data_sync_q) begin
                    state_d = S_DONE;
                end else if (clk_fall) begin
                    cnt_d = '0;
                end else if (timed_out) begin
                    state_d  = S_DONE;
                    err_d    = 1'b1;
                    ack_ok_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                data_oe_d = 1'b0;
                state_d   = S_IDLE;
            end
            default: begin
                state_d   = S_IDLE;
                data_oe_d = 1'b0;
            end
        endcase
    end

    // The clock line is only ever pulled during inhibit and request; data is
    // only pulled while the host owns it (request-to-send and frame bits).
    assign ps2_clk_oe  = (state_q == S_INHIBIT) || (state_q == S_REQ);
    assign ps2_data_oe = data_oe_q && ((state_q == S_REQ) || (state_q == S_SEND));
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign ack_ok      = ack_ok_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx
// Drives ps2_host_tx with a behavioural PS/2 device that clocks at a 40-clk
// period, samples host data on rising edges and optionally acknowledges.
// A per-cycle reference model derives the expected line and status outputs
// from the transfer timeline (inhibit, request, frame, done) and the
// expected frame contents from the byte value with plain arithmetic.
module tb_ps2_host_tx;

   localparam int INHIBIT = 20;
   localparam int REQ     = 4;
   localparam int TMO     = 200;
   localparam int HALF    = 20;

   logic       clk = 1'b0;
   logic       reset;
   logic       start;
   logic [7:0] tx_data;
   logic       ps2_clk_in;
   logic       ps2_data_in;
   logic       ps2_clk_oe;
   logic       ps2_data_oe;
   logic       busy;
   logic       done;
   logic       ack_ok;
   logic       err_timeout;

   logic devClkLow;
   logic devDataLow;

   int nVectors    = 0;
   int nMiscompares = 0;
   int cyc         = 0;
   int phase       = 0;
   int mStart      = 0;
   int doneCount   = 0;
   int lastDoneCyc = 0;
   int lastFallCyc = 0;
   logic mAck      = 1'b0;
   logic mErr      = 1'b0;
   logic expAck    = 1'b0;
   logic expErr    = 1'b0;

   // Open-drain wired lines with pull-ups.
   assign ps2_clk_in  = ~(ps2_clk_oe | devClkLow);
   assign ps2_data_in = ~(ps2_data_oe | devDataLow);

   always #5 clk = ~clk;

   ps2_host_tx #(
      .INHIBIT_CYCLES (INHIBIT),
      .REQ_HOLD_CYCLES(REQ),
      .TIMEOUT_CYCLES (TMO)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .tx_data    (tx_data),
      .ps2_clk_in (ps2_clk_in),
      .ps2_data_in(ps2_data_in),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_data_oe(ps2_data_oe),
      .busy       (busy),
      .done       (done),
      .ack_ok     (ack_ok),
      .err_timeout(err_timeout)
   );

   // Expected 11-bit frame as seen on the wire, bit 0 first:
   // start 0, data LSB first, odd parity, stop 1.
   function automatic logic [10:0] expFrame(input logic [7:0] b);
      logic par;
      par = (($countones(b) % 2) == 0);
      return {1'b1, par, b, 1'b0};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nVectors++;
      if (act !== exp) begin
         nMiscompares++;
         $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Per-cycle reference model and compare, sampled 1 time unit after each
   // rising clk edge. phase: 0 idle, 1 transfer active, 2 leaving done.
   always @(posedge clk) begin
      int rel;
      #1;
      cyc++;
      if (reset) begin
         phase = 0;
         mAck  = 1'b0;
         mErr  = 1'b0;
         checkOutput("reset_clk_oe", 32'(ps2_clk_oe), 0);
         checkOutput("reset_data_oe", 32'(ps2_data_oe), 0);
         checkOutput("reset_busy", 32'(busy), 0);
         checkOutput("reset_done", 32'(done), 0);
         checkOutput("reset_ack_ok", 32'(ack_ok), 0);
         checkOutput("reset_err", 32'(err_timeout), 0);
      end else if (phase == 1) begin
         rel = cyc - mStart;
         checkOutput("active_busy", 32'(busy), 1);
         if (rel < INHIBIT) begin
            checkOutput("inhibit_clk_oe", 32'(ps2_clk_oe), 1);
            checkOutput("inhibit_data_oe", 32'(ps2_data_oe), 0);
            checkOutput("inhibit_done", 32'(done), 0);
            checkOutput("inhibit_ack_clear", 32'(ack_ok), 0);
            checkOutput("inhibit_err_clear", 32'(err_timeout), 0);
         end else if (rel < INHIBIT + REQ) begin
            checkOutput("req_clk_oe", 32'(ps2_clk_oe), 1);
            checkOutput("req_data_oe", 32'(ps2_data_oe), 1);
            checkOutput("req_done", 32'(done), 0);
         end else begin
            checkOutput("send_clk_oe", 32'(ps2_clk_oe), 0);
            if (done) begin
               checkOutput("done_data_oe", 32'(ps2_data_oe), 0);
               checkOutput("done_ack_ok", 32'(ack_ok), 32'(expAck));
               checkOutput("done_err_timeout", 32'(err_timeout), 32'(expErr));
               mAck        = expAck;
               mErr        = expErr;
               phase       = 2;
               lastDoneCyc = cyc;
               doneCount++;
            end
         end
      end else begin
         if (phase == 0 && start) begin
            phase  = 1;
            mStart = cyc;
            checkOutput("accept_busy", 32'(busy), 1);
            checkOutput("accept_clk_oe", 32'(ps2_clk_oe), 1);
            checkOutput("accept_ack_clear", 32'(ack_ok), 0);
            checkOutput("accept_err_clear", 32'(err_timeout), 0);
         end else begin
            phase = 0;
            checkOutput("idle_busy", 32'(busy), 0);
            checkOutput("idle_clk_oe", 32'(ps2_clk_oe), 0);
            checkOutput("idle_data_oe", 32'(ps2_data_oe), 0);
            checkOutput("idle_done", 32'(done), 0);
            checkOutput("idle_ack_hold", 32'(ack_ok), 32'(mAck));
            checkOutput("idle_err_hold", 32'(err_timeout), 32'(mErr));
         end
      end
   end

   task automatic applyStimulus(input logic [7:0] b);
      @(negedge clk);
      tx_data = b;
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
      tx_data = 8'($urandom);
   endtask

   // Behavioural device: waits for the request-to-send, then produces
   // nEdges clock pulses, sampling data on each rising edge. With 11 edges
   // the last pulse is the acknowledge slot, where the device optionally
   // pulls data low.
   task automatic deviceFrame(input int nEdges, input bit ackLow, output logic [10:0] seen);
      int g;
      seen = '0;
      g = 0;
      while (!(ps2_clk_oe === 1'b0 && ps2_data_oe === 1'b1) && g < 200) begin
         @(negedge clk);
         g++;
      end
      nVectors++;
      if (g >= 200) begin
         nMiscompares++;
         $display("[TB] FAIL request_to_send: lines not in send state after %0d cycles, required within 200", g);
         return;
      end
      repeat (HALF / 2) @(negedge clk);
      seen[0] = ps2_data_in;
      for (int i = 1; i <= nEdges; i++) begin
         devClkLow   = 1'b1;
         lastFallCyc = cyc;
         repeat (HALF) @(negedge clk);
         devClkLow   = 1'b0;
         devDataLow  = 1'b0;
         if (i <= 10) seen[i] = ps2_data_in;
         if (i < nEdges) begin
            repeat (HALF / 2) @(negedge clk);
            if (i == 10 && ackLow) devDataLow = 1'b1;
            repeat (HALF / 2) @(negedge clk);
         end
      end
   endtask

   task automatic waitDone(input int dc);
      int g;
      g = 0;
      while (doneCount == dc && g < 1500) begin
         @(negedge clk);
         g++;
      end
      nVectors++;
      if (doneCount == dc) begin
         nMiscompares++;
         $display("[TB] FAIL done_wait: no done pulse after %0d cycles, required within 1500", g);
      end
   endtask

   task automatic checkFrame(input string name, input logic [7:0] b, input int nEdges, input logic [10:0] seen);
      logic [10:0] expBits;
      logic [10:0] mask;
      int n;
      n = (nEdges > 10) ? 10 : nEdges;
      expBits = expFrame(b);
      mask = 11'((1 << (n + 1)) - 1);
      checkOutput(name, 32'(seen & mask), 32'(expBits & mask));
   endtask

   task automatic runTransfer(input logic [7:0] b, input int nEdges, input bit ackLow, input bit poke);
      logic [10:0] seen;
      int dc;
      int delta;
      expAck = (nEdges >= 11) && ackLow;
      expErr = (nEdges < 11);
      dc = doneCount;
      applyStimulus(b);
      if (poke) begin
         fork
            deviceFrame(nEdges, ackLow, seen);
            begin
               repeat (120) @(negedge clk);
               tx_data = 8'h00;
               start   = 1'b1;
               @(negedge clk);
               start   = 1'b0;
            end
         join
      end else begin
         deviceFrame(nEdges, ackLow, seen);
      end
      waitDone(dc);
      checkFrame("frame_bits", b, nEdges, seen);
      if (nEdges < 11 && nEdges > 0) begin
         delta = lastDoneCyc - lastFallCyc;
         nVectors++;
         if (delta < TMO + 2 || delta > TMO + 4) begin
            nMiscompares++;
            $display("[TB] FAIL timeout_delay: done %0d cycles after last edge, required %0d..%0d", delta, TMO + 2, TMO + 4);
         end
      end
   endtask

   // Global watchdog so a stuck design still ends the run.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [10:0] f;
      logic [10:0] seen;
      int dc;

      reset      = 1'b1;
      start      = 1'b0;
      tx_data    = 8'h00;
      devClkLow  = 1'b0;
      devDataLow = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      // Hand-computed frames pin the reference model.
      f = expFrame(8'hED);
      checkOutput("pin_frame_ED", 32'(f), 32'h7DA);
      f = expFrame(8'hF4);
      checkOutput("pin_frame_F4", 32'(f), 32'h5E8);
      f = expFrame(8'h01);
      checkOutput("pin_frame_01", 32'(f), 32'h402);

      $display("[TB] send 0xED with acknowledge");
      runTransfer(8'hED, 11, 1'b1, 1'b0);
      $display("[TB] send 0xF4 without acknowledge");
      runTransfer(8'hF4, 11, 1'b0, 1'b0);
      $display("[TB] device stops after 5 edges");
      runTransfer(8'h96, 5, 1'b0, 1'b0);
      $display("[TB] back-to-back start, second start poked during frame");
      runTransfer(8'hA5, 11, 1'b1, 1'b1);
      runTransfer(8'h3C, 11, 1'b1, 1'b0);

      $display("[TB] reset during frame bit 4");
      expAck = 1'b0;
      expErr = 1'b0;
      applyStimulus(8'h5A);
      deviceFrame(4, 1'b0, seen);
      checkFrame("partial_frame_bits", 8'h5A, 4, seen);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      dc = doneCount;
      repeat (400) @(negedge clk);
      checkOutput("no_done_after_reset", 32'(doneCount), 32'(dc));
      runTransfer(8'h01, 11, 1'b1, 1'b0);

      $display("[TB] randomized transfers");
      for (int k = 0; k < 8; k++) begin
         repeat ($urandom_range(0, 5)) @(negedge clk);
         runTransfer(8'($urandom), 11, 1'($urandom_range(0, 1)), 1'b0);
      end
      repeat (5) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
      $finish;
   end

endmodule
